// File: rtl/spi_pixel_tx.sv
// SPI mode-0 pixel word transmitter: one-deep holding register feeding a 16-edge MSB-first shifter.
// Optional SPI_CS_EN adds an active-low chip select with a one-cycle setup before each burst.
module spi_pixel_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              busy,
    output logic              word_done
`ifdef SPI_CS_EN
    ,
    output logic              spi_cs_n
`endif
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        START = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                spi_clk_q, spi_clk_d;
    logic                spi_mosi_q, spi_mosi_d;
    logic                busy_q, busy_d;
    logic                word_done_q, word_done_d;
    logic                cs_n_q, cs_n_d;
    logic                load;

    // Next-state: phase timing, bit stepping, reload from hold and input accept
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        spi_clk_d    = spi_clk_q;
        spi_mosi_d   = spi_mosi_q;
        busy_d       = busy_q;
        word_done_d  = 1'b0;
        cs_n_d       = cs_n_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                spi_clk_d = 1'b0;
                busy_d    = 1'b0;
`ifdef SPI_CS_EN
                cs_n_d = !hold_valid_q;
                if (hold_valid_q) begin
                    state_d = START;
                end
`else
                if (hold_valid_q) begin
                    load = 1'b1;
                end
`endif
            end
            START: begin
                load = 1'b1;
            end
            SHIFT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (!spi_clk_q) begin
                        spi_clk_d = 1'b1;
                    end else begin
                        spi_clk_d = 1'b0;
                        if (bit_q != '0) begin
                            bit_d      = bit_q - BIT_W'(1);
                            spi_mosi_d = shift_q[bit_q - BIT_W'(1)];
                        end else begin
                            word_done_d = 1'b1;
                            if (hold_valid_q) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading puts the first bit on mosi immediately so the low phase is a full CLK_DIV
        if (load) begin
            state_d      = SHIFT;
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            bit_d        = BIT_TOP;
            cnt_d        = '0;
            spi_mosi_d   = hold_data_q[DATA_W-1];
            busy_d       = 1'b1;
        end

        if (tx_valid && !hold_valid_q) begin
            hold_data_d  = tx_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_q        <= BIT_TOP;
            cnt_q        <= '0;
            spi_clk_q    <= 1'b0;
            spi_mosi_q   <= 1'b0;
            busy_q       <= 1'b0;
            word_done_q  <= 1'b0;
            cs_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            spi_clk_q    <= spi_clk_d;
            spi_mosi_q   <= spi_mosi_d;
            busy_q       <= busy_d;
            word_done_q  <= word_done_d;
            cs_n_q       <= cs_n_d;
        end
    end

    assign tx_ready  = !hold_valid_q;
    assign spi_clk   = spi_clk_q;
    assign spi_mosi  = spi_mosi_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;
`ifdef SPI_CS_EN
    assign spi_cs_n  = cs_n_q;
`else
    logic unused_cs;
    assign unused_cs = cs_n_q ^ cs_n_d;
`endif

endmodule

// File: tb/tb_spi_pixel_tx.sv
// Scoreboard bench for spi_pixel_tx: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1.
module tb_spi_pixel_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        tx_ready0, tx_ready1;
    logic        spi_clk0, spi_clk1;
    logic        spi_mosi0, spi_mosi1;
    logic        busy0, busy1;
    logic        word_done0, word_done1;
`ifdef SPI_CS_EN
    logic        cs_n0, cs_n1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_pixel_tx #(.CLK_DIV(2), .DATA_W(16)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .spi_clk(spi_clk0), .spi_mosi(spi_mosi0),
        .busy(busy0), .word_done(word_done0)
`ifdef SPI_CS_EN
        , .spi_cs_n(cs_n0)
`endif
    );

    spi_pixel_tx #(.CLK_DIV(1), .DATA_W(16)) dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .spi_clk(spi_clk1), .spi_mosi(spi_mosi1),
        .busy(busy1), .word_done(word_done1)
`ifdef SPI_CS_EN
        , .spi_cs_n(cs_n1)
`endif
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: assemble mosi at spi_clk rising edges, compare against queue on word_done
    logic [15:0] acc[2];
    int          nedge[2];
    int          last_rise[2];
    int          last_done[2];
    logic        in_burst[2];
    logic        cont[2];
    logic        prev_sc[2];
    logic        prev_mo[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            acc[i] = '0; nedge[i] = 0; last_rise[i] = 0; last_done[i] = 0;
            in_burst[i] = 1'b0; cont[i] = 1'b0; prev_sc[i] = 1'b0; prev_mo[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        sc, mo, bz, dn;
            logic [15:0] exp_w;
            int          div;
            sc  = (i == 0) ? spi_clk0 : spi_clk1;
            mo  = (i == 0) ? spi_mosi0 : spi_mosi1;
            bz  = (i == 0) ? busy0 : busy1;
            dn  = (i == 0) ? word_done0 : word_done1;
            div = (i == 0) ? 2 : 1;
            if (reset) begin
                acc[i] = '0; nedge[i] = 0; in_burst[i] = 1'b0; cont[i] = 1'b0;
            end else begin
                if (sc && prev_sc[i]) chk("mosi_stable_high", 32'(mo), 32'(prev_mo[i]));
                if (sc && !prev_sc[i]) begin
                    if (in_burst[i]) chk("sclk_period", 32'(cyc - last_rise[i]), 32'(2 * div));
                    in_burst[i]  = 1'b1;
                    last_rise[i] = cyc;
                    acc[i]       = {acc[i][14:0], mo};
                    nedge[i]++;
                end
                if (!bz) in_burst[i] = 1'b0;
                if (dn) begin
                    chk("edges_per_word", 32'(nedge[i]), 32'd16);
                    if (i == 0 && q0.size() > 0) exp_w = q0.pop_front();
                    else if (i == 1 && q1.size() > 0) exp_w = q1.pop_front();
                    else begin
                        exp_w = ~acc[i];
                        $display("FAIL unexpected_word inst%0d: got %h with nothing expected", i, acc[i]);
                    end
                    chk("word_data", 32'(acc[i]), 32'(exp_w));
                    if (cont[i]) chk("done_spacing", 32'(cyc - last_done[i]), 32'(32 * div));
                    cont[i]      = bz;
                    last_done[i] = cyc;
                    acc[i]       = '0;
                    nedge[i]     = 0;
                end
            end
            prev_sc[i] = sc;
            prev_mo[i] = mo;
        end
    end

    task automatic send(input int idx, input logic [15:0] data, input logic chk_done);
        int n = 0;
        @(negedge clk);
        while (((idx == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("send_timeout", 32'(n), 32'd0);
        end else begin
            if (chk_done) chk("ready_with_word_done", 32'(word_done0), 32'd1);
            if (idx == 0) begin tx_data0 = data; tx_valid0 = 1'b1; end
            else          begin tx_data1 = data; tx_valid1 = 1'b1; end
            @(posedge clk);
            #1;
            tx_valid0 = 1'b0;
            tx_valid1 = 1'b0;
            tx_data0  = 16'h0;
            tx_data1  = 16'h0;
        end
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        @(negedge clk);
        while (!(((idx == 0) ? busy0 : busy1) === 1'b0 && ((idx == 0) ? tx_ready0 : tx_ready1) === 1'b1)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 32'(n), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int rises;
        reset = 1'b1;
        tx_data0 = '0; tx_data1 = '0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready0), 32'd1);
        chk("rst_spi_clk", 32'(spi_clk0), 32'd0);
        chk("rst_spi_mosi", 32'(spi_mosi0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_word_done", 32'(word_done0), 32'd0);
`ifdef SPI_CS_EN
        chk("rst_cs_n", 32'(cs_n0), 32'd1);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: latency, 64-cycle word, busy drop
        q0.push_back(16'hA5C3);
        send(0, 16'hA5C3, 1'b0);
        @(negedge clk);
        chk("t1_busy_before_load", 32'(busy0), 32'd0);
`ifdef SPI_CS_EN
        @(negedge clk);
        chk("t1_cs_setup_low", 32'(cs_n0), 32'd0);
        chk("t1_cs_setup_sclk", 32'(spi_clk0), 32'd0);
`endif
        @(negedge clk);
        chk("t1_busy_first_bit", 32'(busy0), 32'd1);
        chk("t1_mosi_first_bit", 32'(spi_mosi0), 32'd1);
        chk("t1_sclk_first_bit", 32'(spi_clk0), 32'd0);
        t0 = cyc;
        n  = 0;
        while (word_done0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("t1_word_cycles", 32'(cyc - t0), 32'd64);
        chk("t1_busy_after_done", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("t1_done_one_pulse", 32'(word_done0), 32'd0);
        wait_idle(0);
`ifdef SPI_CS_EN
        chk("t1_cs_idle_high", 32'(cs_n0), 32'd1);
`endif

        // Back-to-back pair
        q0.push_back(16'h1234);
        q0.push_back(16'hFFFF);
        send(0, 16'h1234, 1'b0);
        send(0, 16'hFFFF, 1'b0);
`ifdef SPI_CS_EN
        repeat (40) @(negedge clk);
        chk("t2_cs_low_mid_burst", 32'(cs_n0), 32'd0);
`endif
        wait_idle(0);

        // Hold full: third word waits until the first word ends
        q0.push_back(16'h0F0F);
        q0.push_back(16'hF0F0);
        q0.push_back(16'h5A5A);
        send(0, 16'h0F0F, 1'b0);
        send(0, 16'hF0F0, 1'b0);
        @(negedge clk);
        chk("t3_ready_low_hold_full", 32'(tx_ready0), 32'd0);
        send(0, 16'h5A5A, 1'b1);
        wait_idle(0);

        // Reset at bit 7 of 0xBEEF with a word in hold
        send(0, 16'hBEEF, 1'b0);
        repeat (34) @(negedge clk);
        send(0, 16'h1111, 1'b0);
        @(negedge clk);
        chk("t4_hold_full_before_reset", 32'(tx_ready0), 32'd0);
`ifdef SPI_CS_EN
        chk("t4_cs_low_before_reset", 32'(cs_n0), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t4_spi_clk", 32'(spi_clk0), 32'd0);
        chk("t4_spi_mosi", 32'(spi_mosi0), 32'd0);
        chk("t4_busy", 32'(busy0), 32'd0);
        chk("t4_tx_ready", 32'(tx_ready0), 32'd1);
        chk("t4_word_done", 32'(word_done0), 32'd0);
`ifdef SPI_CS_EN
        chk("t4_cs_n", 32'(cs_n0), 32'd1);
`endif
        rises = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (spi_clk0 === 1'b1 || busy0 === 1'b1) rises++;
        end
        chk("t4_quiet_after_reset", 32'(rises), 32'd0);

        // CLK_DIV=1 word
        q1.push_back(16'h8001);
        send(1, 16'h8001, 1'b0);
        wait_idle(1);

        // Resume on instance 0 after the reset
        q0.push_back(16'h3C96);
        send(0, 16'h3C96, 1'b0);
        wait_idle(0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
